// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and frame-format defaults
// used by both the transmitter and the receiver.
package uart_pkg;

  // Default frame format: 8 data bits, 16 bclk cycles per bit period.
  localparam int LFRAME_DEF     = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Receiver FSM encodings; the three spare codes are treated as illegal.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input. Both flops
// reset to RST_VAL so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  // Shift the raw input through two flops; bit 1 is the metastability-safe copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= {2{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a 16x oversampled bit clock. Qualifies the start bit at
// mid-bit, samples data LSB-first at the centre of each bit, checks the stop
// bit and reports either a one-cycle rx_valid or a one-cycle rx_frame_err.
// A stop bit sampled low parks the FSM in S_BREAK until the line returns high,
// so a held-low line yields one error rather than a stream of phantom frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int LFRAME     = LFRAME_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF  // must be even and >= 4
) (
  input  logic              bclk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [LFRAME-1:0] rx_dout,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_busy
);

  localparam int HALF  = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);

  // Compare points for the oversample counter and the bit counter.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       BIT_LAST = 4'(LFRAME - 1);

  logic              rxd_s;
  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [3:0]        bitcnt_reg;
  logic [LFRAME-1:0] shift_reg;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (bclk),
    .rst_n(rst_n),
    .d    (rxd),
    .q    (rxd_s)
  );

  // Receive FSM with counters, shift register and registered output pulses.
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      bitcnt_reg   <= '0;
      shift_reg    <= '0;
      rx_dout      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      // Pulses are single-cycle unless a branch below raises them.
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (!rxd_s) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
            rx_busy   <= 1'b1;
          end
        end
        S_START: begin
          // Re-check the line half a bit in; a high level here was a glitch.
          if (cnt_reg == CNT_HALF) begin
            cnt_reg <= '0;
            if (!rxd_s) begin
              state_reg  <= S_DATA;
              bitcnt_reg <= '0;
            end else begin
              state_reg <= S_IDLE;
              rx_busy   <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DATA: begin
          // One full bit period after the mid-start point lands mid-data-bit.
          if (cnt_reg == CNT_LAST) begin
            cnt_reg    <= '0;
            shift_reg  <= {rxd_s, shift_reg[LFRAME-1:1]};
            bitcnt_reg <= bitcnt_reg + 4'd1;
            if (bitcnt_reg == BIT_LAST) begin
              state_reg <= S_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (rxd_s) begin
              rx_dout   <= shift_reg;
              rx_valid  <= 1'b1;
              state_reg <= S_IDLE;
              rx_busy   <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              state_reg    <= S_BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxd_s) begin
            state_reg <= S_IDLE;
            rx_busy   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          cnt_reg   <= '0;
          rx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
